// File: rtl/reg_file_alu_pkg.sv
// Shared widths, ALU opcode encoding and flag bundle for the register-file/ALU datapath.
package reg_file_alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NAME_BITS_DEF  = 5;
  localparam int CTRL_BITS_DEF  = 4;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_SEQ  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_SLTU = 4'b1011
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic over;
    logic c_out;
  } alu_flags_t;

endpackage

// File: rtl/reg_file_alu_alu.sv
// Purely combinational ALU; carry/overflow are meaningful only for ADD and SUB.
module rfa_alu
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CTRL_BITS  = CTRL_BITS_DEF
) (
  input  logic [CTRL_BITS-1:0]  op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] c_o,
  output alu_flags_t            flags_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic [SH_W-1:0]       shamt;
  logic [DATA_WIDTH-1:0] c;
  logic                  over;
  logic                  c_out;

  always_comb begin
    add_full = {1'b0, a_i} + {1'b0, b_i};
    // SUB is a + ~b + 1 so its carry out is the "no borrow" indication
    sub_full = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_WIDTH+1)'(1);
    shamt    = b_i[SH_W-1:0];
    c        = '0;
    over     = 1'b0;
    c_out    = 1'b0;
    case (op_i)
      CTRL_BITS'(OP_AND):  c = a_i & b_i;
      CTRL_BITS'(OP_OR):   c = a_i | b_i;
      CTRL_BITS'(OP_XOR):  c = a_i ^ b_i;
      CTRL_BITS'(OP_NOR):  c = ~(a_i | b_i);
      CTRL_BITS'(OP_SEQ):  c = DATA_WIDTH'(a_i == b_i);
      CTRL_BITS'(OP_SLT):  c = DATA_WIDTH'($signed(a_i) < $signed(b_i));
      CTRL_BITS'(OP_SLTU): c = DATA_WIDTH'(a_i < b_i);
      CTRL_BITS'(OP_SLL):  c = a_i << shamt;
      CTRL_BITS'(OP_SRL):  c = a_i >> shamt;
      CTRL_BITS'(OP_SRA):  c = DATA_WIDTH'($signed(a_i) >>> shamt);
      CTRL_BITS'(OP_ADD): begin
        c     = add_full[DATA_WIDTH-1:0];
        c_out = add_full[DATA_WIDTH];
        over  = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                (c[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
      end
      CTRL_BITS'(OP_SUB): begin
        c     = sub_full[DATA_WIDTH-1:0];
        c_out = sub_full[DATA_WIDTH];
        over  = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                (c[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
      end
      default: c = '0;
    endcase
  end

  assign c_o           = c;
  assign flags_o.zero  = (c == '0);
  assign flags_o.over  = over;
  assign flags_o.c_out = c_out;

endmodule

// File: rtl/reg_file_alu.sv
// Single-cycle datapath: register file -> ALU -> word memory -> write-back into the register file.
module reg_file_alu
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NAME_BITS  = NAME_BITS_DEF,
  parameter int CTRL_BITS  = CTRL_BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NAME_BITS-1:0]  rs1,
  input  logic [NAME_BITS-1:0]  rs2,
  input  logic [NAME_BITS-1:0]  ws_in,
  input  logic [CTRL_BITS-1:0]  op_in,
  input  logic                  imm_e,
  input  logic [DATA_WIDTH-1:0] imm_d,
  input  logic                  mem_rst,
  input  logic                  mem_we,
  input  logic                  mem_re,
  input  logic                  mem_rs,
  input  logic                  mem_ws,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  zero,
  output logic                  over,
  output logic                  c_out
);

  localparam int NUM_REGS  = 1 << NAME_BITS;
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_q  [MEM_WORDS];

  logic [DATA_WIDTH-1:0] a_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] b_val;
  logic [DATA_WIDTH-1:0] c_val;
  alu_flags_t            flags;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_word_d;

  // r0 is forced to zero at the read mux so it never depends on reset having happened
  assign a_val   = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs_q[rs2];
  assign b_val   = imm_e ? imm_d : rs2_val;

  rfa_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_BITS  (CTRL_BITS)
  ) u_alu (
    .op_i    (op_in),
    .a_i     (a_val),
    .b_i     (b_val),
    .c_o     (c_val),
    .flags_o (flags)
  );

  assign mem_addr = c_val[ADDR_WIDTH-1:0];
  assign mem_word = mem_q[mem_addr];
  assign mem_rd   = mem_rs ? {{(DATA_WIDTH-8){mem_word[7]}}, mem_word[7:0]} : mem_word;
  // A byte store merges into the current word so the upper bytes survive
  assign mem_word_d = mem_ws ? {mem_word[DATA_WIDTH-1:8], rs2_val[7:0]} : rs2_val;

  assign wb_data = mem_re ? mem_rd : c_val;
  assign zero    = flags.zero;
  assign over    = flags.over;
  assign c_out   = flags.c_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (ws_in != '0) begin
      regs_q[ws_in] <= wb_data;
    end
  end

  // Memory ignores the datapath reset; its own clear wins over a same-edge store
  always_ff @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (rst && mem_we) begin
      mem_q[mem_addr] <= mem_word_d;
    end
  end

endmodule

// File: tb/tb_reg_file_alu.sv
// Scenario bench for reg_file_alu: expected write-back values and flags are queued per cycle and compared.
module tb_reg_file_alu;

  localparam logic [4:0] MC_NONE = 5'b00000;
  localparam logic [4:0] MC_CLR  = 5'b10000;
  localparam logic [4:0] MC_WE   = 5'b01000;
  localparam logic [4:0] MC_RE   = 5'b00100;
  localparam logic [4:0] MC_RS   = 5'b00010;
  localparam logic [4:0] MC_WS   = 5'b00001;

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  w;
    logic        ie;
    logic [31:0] im;
    logic [31:0] exp;
    logic        ov;
    logic        co;
    logic        chkf;
    logic [4:0]  mc;
    logic        r;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, ws_in = '0;
  logic [3:0]  op_in = '0;
  logic        imm_e = 1'b0;
  logic [31:0] imm_d = '0;
  logic        mem_rst = 1'b0, mem_we = 1'b0, mem_re = 1'b0, mem_rs = 1'b0, mem_ws = 1'b0;
  logic [31:0] wb_data;
  logic        zero, over, c_out;

  int   checks   = 0;
  int   failures = 0;
  row_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_alu dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ws_in(ws_in), .op_in(op_in),
    .imm_e(imm_e), .imm_d(imm_d), .mem_rst(mem_rst), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rs(mem_rs), .mem_ws(mem_ws),
    .wb_data(wb_data), .zero(zero), .over(over), .c_out(c_out)
  );

  function automatic row_t mk(string tag, logic [3:0] op, logic [4:0] a, logic [4:0] b,
                              logic [4:0] w, logic ie, logic [31:0] im, logic [31:0] exp,
                              logic ov = 1'b0, logic co = 1'b0, logic chkf = 1'b1,
                              logic [4:0] mc = MC_NONE, logic r = 1'b1);
    row_t x;
    x.tag = tag; x.op = op; x.a = a; x.b = b; x.w = w; x.ie = ie; x.im = im;
    x.exp = exp; x.ov = ov; x.co = co; x.chkf = chkf; x.mc = mc; x.r = r;
    return x;
  endfunction

  // Reads a register through OR with immediate 0, writing nothing back
  function automatic row_t rd(string tag, logic [4:0] idx, logic [31:0] exp);
    return mk(tag, 4'h1, idx, 5'd0, 5'd0, 1'b1, 32'h0, exp);
  endfunction

  task automatic apply(input row_t x);
    @(negedge clk);
    op_in = x.op; rs1 = x.a; rs2 = x.b; ws_in = x.w; imm_e = x.ie; imm_d = x.im;
    {mem_rst, mem_we, mem_re, mem_rs, mem_ws} = x.mc;
    rst = x.r;
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    apply(mk("hold0", 4'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, MC_NONE, 1'b0));
    apply(mk("hold1", 4'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, MC_NONE, 1'b0));
    rows.push_back(rd("rst_r1", 1, 32'h0));
    rows.push_back(rd("rst_r17", 17, 32'h0));
    rows.push_back(rd("rst_r31", 31, 32'h0));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  task automatic test_alu_basic();
    row_t rows[$];
    row_t e;
    rows.push_back(mk("or_imm_r1",  4'h1, 0, 0, 1, 1, 32'h5, 32'h5));
    rows.push_back(mk("or_r1_r2",   4'h1, 1, 0, 2, 0, 32'h0, 32'h5));
    rows.push_back(mk("add_r3",     4'h2, 0, 2, 3, 0, 32'h0, 32'h5));
    rows.push_back(mk("sub_r4",     4'h6, 0, 3, 4, 0, 32'h0, 32'hFFFF_FFFB, 0, 0));
    rows.push_back(mk("set_r6",     4'h1, 0, 0, 6, 1, 32'h5, 32'h5));
    rows.push_back(mk("set_r7",     4'h1, 0, 0, 7, 1, 32'h5, 32'h5));
    rows.push_back(mk("seq_r6",     4'h5, 7, 6, 6, 0, 32'h0, 32'h1));
    rows.push_back(mk("slt_r5",     4'h7, 0, 2, 5, 0, 32'h0, 32'h1));
    rows.push_back(mk("set_r9",     4'h1, 0, 0, 9, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
    rows.push_back(mk("add_ovf",    4'h2, 9, 0, 0, 1, 32'h1, 32'h8000_0000, 1, 0));
    rows.push_back(rd("chk_r1", 1, 32'h5));
    rows.push_back(rd("chk_r2", 2, 32'h5));
    rows.push_back(rd("chk_r3", 3, 32'h5));
    rows.push_back(rd("chk_r4", 4, 32'hFFFF_FFFB));
    rows.push_back(rd("chk_r5", 5, 32'h1));
    rows.push_back(rd("chk_r6", 6, 32'h1));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  // r1=5, r4=0xFFFFFFFB (-5), r9=0x7FFFFFFF at this point
  task automatic test_ops();
    row_t rows[$];
    row_t e;
    rows.push_back(mk("and",       4'h0, 4, 0, 0, 1, 32'hF0, 32'hF0));
    rows.push_back(mk("xor",       4'h3, 1, 0, 0, 1, 32'h3, 32'h6));
    rows.push_back(mk("nor",       4'h4, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFF));
    rows.push_back(mk("sll_b5",    4'h8, 1, 0, 0, 1, 32'h24, 32'h50));
    rows.push_back(mk("srl",       4'h9, 4, 0, 0, 1, 32'h1C, 32'hF));
    rows.push_back(mk("sra",       4'hA, 4, 0, 0, 1, 32'h1, 32'hFFFF_FFFD));
    rows.push_back(mk("sltu_t",    4'hB, 1, 4, 0, 0, 32'h0, 32'h1));
    rows.push_back(mk("sltu_f",    4'hB, 4, 1, 0, 0, 32'h0, 32'h0));
    rows.push_back(mk("slt_t",     4'h7, 4, 1, 0, 0, 32'h0, 32'h1));
    rows.push_back(mk("slt_f",     4'h7, 1, 4, 0, 0, 32'h0, 32'h0));
    rows.push_back(mk("sub_zero",  4'h6, 1, 0, 0, 1, 32'h5, 32'h0, 0, 1));
    rows.push_back(mk("add_carry", 4'h2, 4, 0, 0, 1, 32'h5, 32'h0, 0, 1));
    rows.push_back(mk("sub_ovf",   4'h6, 9, 0, 0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0));
    rows.push_back(mk("seq_f",     4'h5, 1, 0, 0, 1, 32'h6, 32'h0));
    rows.push_back(mk("op_c",      4'hC, 4, 0, 0, 1, 32'h5, 32'h0));
    rows.push_back(mk("op_f",      4'hF, 4, 0, 0, 1, 32'h5, 32'h0));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  task automatic test_mem();
    row_t rows[$];
    row_t e;
    rows.push_back(mk("mem_clr",   4'h1, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0, MC_CLR));
    rows.push_back(mk("st_m3",     4'h2, 0, 1, 0, 1, 32'h3, 32'h3, 0, 0, 0, MC_WE));
    rows.push_back(mk("ld_m3_r8",  4'h2, 0, 0, 8, 1, 32'h3, 32'h5, 0, 0, 0, MC_RE));
    rows.push_back(rd("chk_r8", 8, 32'h5));
    rows.push_back(mk("set_r10",   4'h1, 0, 0, 10, 1, 32'h1122_3344, 32'h1122_3344));
    rows.push_back(mk("st_m4",     4'h2, 0, 10, 0, 1, 32'h4, 32'h4, 0, 0, 0, MC_WE));
    rows.push_back(mk("ld_m4",     4'h2, 0, 0, 0, 1, 32'h4, 32'h1122_3344, 0, 0, 0, MC_RE));
    rows.push_back(mk("set_r11",   4'h1, 0, 0, 11, 1, 32'h80, 32'h80));
    rows.push_back(mk("stb_m4",    4'h2, 0, 11, 0, 1, 32'h4, 32'h4, 0, 0, 0, MC_WE | MC_WS));
    rows.push_back(mk("ld_m4_w",   4'h2, 0, 0, 0, 1, 32'h4, 32'h1122_3380, 0, 0, 0, MC_RE));
    rows.push_back(mk("ld_m4_b",   4'h2, 0, 0, 0, 1, 32'h4, 32'hFFFF_FF80, 0, 0, 0, MC_RE | MC_RS));
    rows.push_back(mk("ld_m3_b",   4'h2, 0, 0, 0, 1, 32'h3, 32'h5, 0, 0, 0, MC_RE | MC_RS));
    rows.push_back(mk("ld_alias",  4'h2, 0, 0, 0, 1, 32'h104, 32'h1122_3380, 0, 0, 0, MC_RE));
    rows.push_back(mk("clr_vs_st", 4'h2, 0, 10, 0, 1, 32'h3, 32'h3, 0, 0, 0, MC_CLR | MC_WE));
    rows.push_back(mk("ld_m3_clr", 4'h2, 0, 0, 0, 1, 32'h3, 32'h0, 0, 0, 0, MC_RE));
    rows.push_back(mk("ld_m4_clr", 4'h2, 0, 0, 0, 1, 32'h4, 32'h0, 0, 0, 0, MC_RE));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    row_t e;
    rows.push_back(mk("st_m5",     4'h2, 0, 10, 0, 1, 32'h5, 32'h5, 0, 0, 0, MC_WE));
    rows.push_back(mk("rst_cycle", 4'h1, 0, 1, 12, 1, 32'h77, 32'h77, 0, 0, 0, MC_WE, 1'b0));
    rows.push_back(rd("post_r1", 1, 32'h0));
    rows.push_back(rd("post_r10", 10, 32'h0));
    rows.push_back(rd("post_r12", 12, 32'h0));
    rows.push_back(rd("post_r8", 8, 32'h0));
    rows.push_back(mk("ld_m77",    4'h2, 0, 0, 0, 1, 32'h77, 32'h0, 0, 0, 0, MC_RE));
    rows.push_back(mk("ld_m5_keep", 4'h2, 0, 0, 0, 1, 32'h5, 32'h1122_3344, 0, 0, 0, MC_RE));
    rows.push_back(mk("wr_r0",     4'h1, 0, 0, 0, 1, 32'hAB, 32'hAB));
    rows.push_back(rd("chk_r0", 0, 32'h0));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    rows.push_back(mk("b2b_set", 4'h1, 0, 0, 1, 1, 32'h1, 32'h1));
    for (int k = 2; k <= 4; k++) rows.push_back(mk("b2b_inc", 4'h2, 1, 0, 1, 1, 32'h1, 32'(k)));
    rows.push_back(rd("b2b_r1", 1, 32'h4));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i]);
      apply(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.exp) begin
        failures++; $display("FAIL %s wb_data got=%h expected=%h", e.tag, wb_data, e.exp);
      end
      if (e.chkf) begin
        checks++;
        if ({zero, over, c_out} !== {e.exp == 32'h0, e.ov, e.co}) begin
          failures++; $display("FAIL %s flags got=%b expected=%b", e.tag, {zero, over, c_out}, {e.exp == 32'h0, e.ov, e.co});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_ops();
    test_mem();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
